// File: rtl/neg_share_arbiter.sv
// Round-robin share of one N-bit two's-complement negator among REQ requesters, one registered result slot.
// Latency: operand granted in cycle t appears on rsp_* from cycle t+1; one result per cycle when rsp_ready stays high.
// Backpressure: while a result is held and rsp_ready=0, no grant is issued and rsp_* stay frozen.
module neg_share_arbiter #(
    parameter int N   = 4,
    parameter int REQ = 4,
    parameter int IDW = (REQ > 1) ? $clog2(REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ-1:0]     req_valid,
    input  logic [REQ*N-1:0]   req_data,
    output logic [REQ-1:0]     req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [N-1:0]       rsp_data,
    output logic [IDW-1:0]     rsp_id,
    output logic               rsp_ovf
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   data_q, data_d;
    logic [IDW-1:0] id_q, id_d;
    logic           ovf_q, ovf_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [N-1:0]   grant_op;
    logic           accept;

    // Invert-and-add-one as an explicit ripple; the final carry is dropped.
    function automatic logic [N-1:0] negate(input logic [N-1:0] a);
        logic [N-1:0] r;
        logic         c;
        c = 1'b1;
        r = '0;
        for (int b = 0; b < N; b++) begin
            r[b] = (~a[b]) ^ c;
            c    = (~a[b]) & c;
        end
        return r;
    endfunction

    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= REQ) begin
                idx = idx - REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    assign grant_op = req_data[grant_idx*N +: N];
    assign accept   = grant_found && ((state_q == EMPTY) || rsp_ready);

    // Grant is masked during reset so no operand is consumed while flops are held.
    always_comb begin
        req_ready = '0;
        req_ready[grant_idx] = accept && rst_n;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        ovf_d   = ovf_q;
        if (accept) begin
            state_d = FULL;
            data_d  = negate(grant_op);
            id_d    = grant_idx;
            ovf_d   = (grant_op == MOST_NEG);
            ptr_d   = (grant_idx == IDW'(REQ-1)) ? '0 : grant_idx + IDW'(1);
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_neg_share_arbiter.sv
// Directed and short random checks of neg_share_arbiter with N=4, REQ=4.
module tb_neg_share_arbiter;
    localparam int N   = 4;
    localparam int REQ = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REQ-1:0]   req_valid;
    logic [REQ*N-1:0] req_data;
    logic [REQ-1:0]   req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_data;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] rr_exp [4];
    int         ptr_m, g, waitc [REQ];
    bit         found, acc, full_m;
    logic [3:0] m_data, op;
    logic [1:0] m_id;
    logic       m_ovf;

    neg_share_arbiter #(.N(N), .REQ(REQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] v);
        req_data[i*N +: N] = v;
    endtask

    function automatic logic [3:0] neg_ref(input logic [3:0] a);
        return 4'((16 - int'(a)) % 16);
    endfunction

    initial begin
        rr_exp = '{4'hF, 4'hE, 4'hB, 4'h9};
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        rsp_ready = 1'b0;

        // reset state, grant suppressed even with all requests pending
        @(negedge clk); #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_ovf", rsp_ovf, 0);
        chk("rst_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;

        // single request: 3 -> D
        @(negedge clk);
        req_valid = 4'b0100; set_op(2, 4'd3); rsp_ready = 1'b1;
        #1 chk("single_grant", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("single_valid", rsp_valid, 1);
        chk("single_data", rsp_data, 4'hD);
        chk("single_id", rsp_id, 2);
        chk("single_ovf", rsp_ovf, 0);
        @(negedge clk); #1;
        chk("drain_valid", rsp_valid, 0);
        chk("drain_hold_data", rsp_data, 4'hD);

        // fill the slot, then reset asynchronously mid-cycle
        @(negedge clk);
        req_valid = 4'b0001; set_op(0, 4'h6); rsp_ready = 1'b0;
        #1 chk("fill_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("fill_data", rsp_data, 4'hA);
        chk("fill_bp_ready", req_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", rsp_valid, 0);
        chk("async_rst_data", rsp_data, 0);
        chk("async_rst_ready", req_ready, 0);

        // round robin from pointer 0, no bubbles
        set_op(0, 4'd1); set_op(1, 4'd2); set_op(2, 4'd5); set_op(3, 4'd7);
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("rr_grant", req_ready, 32'(1 << (k % 4)));
            if (k > 0) begin
                chk("rr_valid", rsp_valid, 1);
                chk("rr_id", rsp_id, 32'((k - 1) % 4));
                chk("rr_data", rsp_data, rr_exp[(k - 1) % 4]);
            end
        end

        // backpressure for several cycles, result held
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("bp_id0", rsp_id, 0);
        chk("bp_data0", rsp_data, 4'hF);
        chk("bp_ready0", req_ready, 0);
        repeat (5) begin
            @(negedge clk); #1;
            chk("bp_ready", req_ready, 0);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 0);
            chk("bp_data", rsp_data, 4'hF);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1 chk("bp_resume_grant", req_ready, 4'b0010);

        // boundary operands through requester 0
        @(negedge clk);
        req_valid = 4'b0001; set_op(0, 4'h8);
        #1;
        chk("resume_id", rsp_id, 1);
        chk("resume_data", rsp_data, 4'hE);
        chk("b8_grant", req_ready, 4'b0001);
        @(negedge clk);
        set_op(0, 4'h0);
        #1;
        chk("b8_data", rsp_data, 4'h8);
        chk("b8_ovf", rsp_ovf, 1);
        chk("b0_grant", req_ready, 4'b0001);
        @(negedge clk);
        set_op(0, 4'hF);
        #1;
        chk("b0_data", rsp_data, 4'h0);
        chk("b0_ovf", rsp_ovf, 0);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("bF_data", rsp_data, 4'h1);
        chk("bF_ovf", rsp_ovf, 0);

        // random traffic against a behavioural model
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        ptr_m = 0; full_m = 0; m_data = '0; m_id = '0; m_ovf = 1'b0;
        for (int i = 0; i < REQ; i++) waitc[i] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req_valid = 4'($urandom_range(0, 15));
            req_data  = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            found = 0; g = 0;
            for (int k = 0; k < REQ; k++) begin
                if (!found && req_valid[(ptr_m + k) % REQ]) begin
                    found = 1; g = (ptr_m + k) % REQ;
                end
            end
            acc = found && (!full_m || rsp_ready);
            chk("rnd_ready", req_ready, acc ? 32'(1 << g) : 32'd0);
            chk("rnd_valid", rsp_valid, full_m);
            if (full_m) begin
                chk("rnd_data", rsp_data, m_data);
                chk("rnd_id", rsp_id, m_id);
                chk("rnd_ovf", rsp_ovf, m_ovf);
            end
            for (int i = 0; i < REQ; i++) begin
                if (!req_valid[i]) begin
                    waitc[i] = 0;
                end else if (acc && i == g) begin
                    chk("rnd_fair", 32'(waitc[i] <= REQ - 1), 1);
                    waitc[i] = 0;
                end else if (acc) begin
                    waitc[i]++;
                end
            end
            if (acc) begin
                op     = req_data[g*N +: N];
                m_data = neg_ref(op);
                m_id   = 2'(g);
                m_ovf  = (op == 4'h8);
                ptr_m  = (g + 1) % REQ;
                full_m = 1;
            end else if (full_m && rsp_ready) begin
                full_m = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
